// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential imem reads and buffers
// {pc, ir} pairs in a small FIFO that feeds the IF-stage decoder.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] ir_o,
  output logic [31:0] pc_o
);

  localparam int              CW          = $clog2(DEPTH + 1);
  localparam int              AW          = $clog2(DEPTH);
  localparam logic [CW:0]     L_DEPTH     = (CW + 1)'(DEPTH);
  localparam logic [AW-1:0]   L_LAST      = AW'(DEPTH - 1);
  localparam logic [31:0]     L_RESET_PC  = {RESET_PC[31:2], 2'b00};

  logic [31:0]   r_pc;
  logic [31:0]   r_req_pc;
  logic [CW-1:0] r_cnt;
  logic          r_inflight;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [31:0]   r_buf_pc [DEPTH];
  logic [31:0]   r_buf_ir [DEPTH];

  logic [CW:0]   w_occ;
  logic          w_deq;
  logic          w_push;
  logic          w_room;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    if (p == L_LAST) return '0;
    return p + AW'(1);
  endfunction

  // Handshake: the head entry transfers on every rising edge where valid_o
  // and ready_i are both high; until then pc_o/ir_o hold their value, and only
  // a redirect or reset may withdraw valid_o.
  assign valid_o = (r_cnt != '0);
  assign w_deq   = valid_o && ready_i;
  assign pc_o    = r_buf_pc[r_head];
  assign ir_o    = r_buf_ir[r_head];

  // Count the in-flight read as occupied so its response always has a slot.
  assign w_occ       = {1'b0, r_cnt} + {{CW{1'b0}}, r_inflight};
  assign w_room      = (w_occ < L_DEPTH) || ((w_occ == L_DEPTH) && w_deq);
  assign imem_req_o  = !rst_i && !redirect_i && w_room;
  assign imem_addr_o = r_pc;
  assign w_push      = r_inflight && !redirect_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc       <= L_RESET_PC;
      r_cnt      <= '0;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
    end else if (redirect_i) begin
      r_pc       <= redirect_pc_i & 32'hFFFF_FFFC;
      r_cnt      <= '0;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_inflight <= imem_req_o;
      if (imem_req_o) r_pc <= r_pc + 32'd4;
      if (w_push)     r_tail <= ptr_next(r_tail);
      if (w_deq)      r_head <= ptr_next(r_head);
      case ({w_push, w_deq})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // Datapath storage carries no reset; valid_o gates every use of it.
  always_ff @(posedge clk_i) begin
    if (imem_req_o) r_req_pc <= r_pc;
    if (w_push) begin
      r_buf_pc[r_tail] <= r_req_pc;
      r_buf_ir[r_tail] <= imem_rdata_i;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && !w_deq && ({1'b0, r_cnt} == L_DEPTH)));

  a_addr_aligned: assert property (@(posedge clk_i) disable iff (rst_i)
    imem_addr_o[1:0] == 2'b00);

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the address of the first fetch after reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the number of fetch-buffer entries; legal values are 2..8.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port imem_req_o, output, 1 bit: instruction-memory read request this cycle.
REQ-006 SHALL have port imem_addr_o, output, 32 bits: read address; bits [1:0] always 0.
REQ-007 SHALL have port imem_rdata_i, input, 32 bits: read data, valid exactly one cycle after the matching request.
REQ-008 SHALL have port redirect_i, input, 1 bit: flush and restart fetch (taken branch/jump, from EX).
REQ-009 SHALL have port redirect_pc_i, input, 32 bits: restart address; bits [1:0] are ignored and treated as 0.
REQ-010 SHALL have port valid_o, output, 1 bit: ir_o/pc_o hold a valid instruction for the IF decoder.
REQ-011 SHALL have port ready_i, input, 1 bit: downstream accepts the head entry this cycle.
REQ-012 SHALL have port ir_o, output, 32 bits: instruction word at the buffer head, driven to the IF-stage decoder.
REQ-013 SHALL have port pc_o, output, 32 bits: address of ir_o.

Function
REQ-014 SHALL hold a fetch PC register (pc_q), a DEPTH-entry FIFO of {pc, ir}, an occupancy count cnt (0..DEPTH), and an in-flight flag inflight_q.
REQ-015 SHALL define deq = valid_o && ready_i; a dequeue pops the head at the clock edge.
REQ-016 SHALL assert imem_req_o = !redirect_i && ((cnt + inflight_q) < DEPTH || ((cnt + inflight_q) == DEPTH && deq)).
REQ-017 SHALL drive imem_addr_o = pc_q; on each issued request, pc_q <= pc_q + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-018 SHALL set inflight_q <= imem_req_o each cycle and capture the request PC in a side register for the response.
REQ-019 SHALL, when inflight_q=1 and no redirect is active this cycle, push {captured pc, imem_rdata_i} into the FIFO at the tail.
REQ-020 SHALL never overflow: a push while cnt==DEPTH without a simultaneous deq is impossible by REQ-016; simultaneous push and deq leaves cnt unchanged.
REQ-021 SHALL drive valid_o = (cnt != 0), with ir_o/pc_o taken from the head entry; outputs SHALL remain stable while valid_o && !ready_i.
REQ-022 SHALL give a latency of 2 cycles: request at edge t, entry visible on valid_o after edge t+2; sustained throughput SHALL be 1 instruction/cycle while ready_i=1.
REQ-023 SHALL, on redirect_i=1 at a clock edge: clear the FIFO (cnt <= 0), discard any in-flight response (no push), set pc_q <= {redirect_pc_i[31:2], 2'b00}, set inflight_q <= 0, and issue no request in that cycle.
REQ-024 SHALL give redirect priority over deq and push in the same cycle; a deq handshake coinciding with redirect still counts as accepted by downstream.
REQ-025 SHALL issue the first request at the new PC in the cycle after the redirect edge.

Reset
REQ-026 SHALL, while rst_i=1, asynchronously force pc_q=RESET_PC, cnt=0, inflight_q=0, valid_o=0, and imem_req_o=0.
REQ-027 SHALL issue its first request (imem_addr_o=RESET_PC) in the first cycle with rst_i=0.
REQ-028 SHALL, if reset is asserted mid-operation, drop all buffered and in-flight entries; no stale entry SHALL appear after release.
REQ-029 SHALL leave FIFO data storage unreset; only the control state is reset.

Verification
REQ-030 Reset release, ready_i=1, memory returns addr ^ 32'hA5A5_0000 -> requests issue at 0, 4, 8 on consecutive cycles; valid_o rises 2 cycles after the first request with pc_o=0 and ir_o=32'hA5A5_0000; one instruction per cycle thereafter.
REQ-031 Back-pressure: ready_i=0 for 5 cycles after the first valid -> cnt saturates at DEPTH=2; imem_req_o=0 while full; pc_o/ir_o hold 0/first word; on ready_i=1, PCs 0, 4, 8, ... are delivered in order with no loss or duplication.
REQ-032 Redirect with an in-flight request: redirect_i=1 with redirect_pc_i=32'h0000_0103 while a request for 0x10 is in flight -> 0x10 never appears on pc_o; the next request address is 0x100; the first valid output has pc_o=0x100 two cycles later.
REQ-033 Simultaneous redirect + deq + push: all three in the same cycle -> valid_o=0 next cycle and cnt=0; no entry from before the redirect is ever emitted.
REQ-034 PC wrap: redirect to 32'hFFFF_FFF8 -> requests at FFFF_FFF8, FFFF_FFFC, 0000_0000 in sequence.
REQ-035 Async reset mid-stream: rst_i pulsed high between clock edges with cnt=2 -> valid_o and imem_req_o drop immediately without waiting for a clock edge; after release, fetch restarts at RESET_PC.
